mux_3x1_merge: RTL
==================

// Module: mux_3x1_merge
// PURPOSE
//  Registered 3-to-1 merge for the CORDIC FPU interface. Recombines the three
//  result channels that were fanned out by the 1x3 channel demux into one output stream.
//  Sources are chosen by forced select (same encoding as the demux) or by round-robin.
//  A grant is held until the chosen channel completes a multi-beat result (last beat).
// PARAMETERS
//  W        32   data width per beat
// PORTS
//  clk        in   1   system clock; single clock domain
//  rst        in   1   synchronous, active-high reset
//  arb_en     in   1   1: round-robin arbitration; 0: forced select
//  select     in   2   forced source: 00 ch1, 01 ch2, 10 ch3, 11 ch2
//  chN_data   in   W   channel N beat, N=1..3
//  chN_valid  in   1   channel N beat valid
//  chN_last   in   1   channel N final beat of result
//  chN_ready  out  1   channel N beat accepted this cycle (valid&ready)
//  data_out   out  W   merged beat (registered)
//  valid_out  out  1   data_out valid
//  last_out   out  1   final beat of result
//  sel_out    out  2   source tag of data_out: 00 ch1, 01 ch2, 10 ch3
//  ready_in   in   1   downstream accepts data_out when valid_out&ready_in
// BEHAVIOUR
//  - Reset: valid_out=0, data_out=0, last_out=0, sel_out=00, all chN_ready=0,
//    FSM=IDLE, rr_last=ch3 so ch1 has top priority after reset.
//  - Output register load enable: ld = !valid_out | ready_in. chN_ready = ld & (grant==N).
//  - Latency: accepted beat appears on data_out the next cycle; 1 beat/cycle
//    sustained when ready_in=1. Bubble: valid_out drops when ld and no beat accepted.
//  - FSM IDLE: candidate = forced select (arb_en=0) or, for arb_en=1, first valid
//    channel after rr_last in order ch1->ch2->ch3->ch1. Forced mode grants
//    regardless of valid; the beat transfers only when the forced channel is valid.
//    On a transfer with last=0: lock grant, go LOCKED. With last=1: stay IDLE.
//    rr_last updates to granted channel on every first beat accepted.
//  - FSM LOCKED: grant fixed to locked channel; select/arb_en changes ignored until
//    release. Return to IDLE on accepted beat with last=1. Locked channel
//    dropping valid: no transfer, lock held. Other channels see ready=0.
//  - Last beat and new request in same cycle: new arbitration occurs next cycle
//    (state IDLE); a single-beat result from IDLE arbitrates and transfers in one cycle.
//  - select=11 behaves exactly as 01 (ch2), including sel_out=01.
//  - Backpressure: ready_in=0 with valid_out=1 holds data_out/last_out/sel_out
//    stable; all chN_ready=0.
//  - Reset mid-LOCKED: FSM->IDLE, valid_out->0; partial result discarded.
//  - No combinational path from chN_valid to chN_ready except through grant in IDLE
//    round-robin; ready_in -> chN_ready is combinational (ld).
// STRUCTURE
//  - Shared package/include: channel encodings CH1=2'b00, CH2=2'b01, CH3=2'b10,
//    FSM state constants IDLE/LOCKED; shared with the 1x3 demux.
//  - One sub-module: rr_arbiter_3 (3 requests, rr_last in, one-hot grant out).
//  - Top holds FSM, lock register, rr_last, output register, ready steering.
// TESTING
//  - Reset then arb_en=0, select=01, ch2 single beat 0xA5, last=1 -> next cycle
//    data_out=0xA5, sel_out=01, last_out=1; ch1/ch3 ready stay 0.
//  - arb_en=1, all three valid single-beat, ready_in=1 -> sel_out 00,01,10,00 on
//    consecutive cycles, no bubbles.
//  - arb_en=1, ch1 3-beat result (last on beat 3) with ch2 valid -> 3 ch1 beats
//    contiguous, then ch2; select toggled mid-lock has no effect.
//  - ready_in=0 for 4 cycles with valid_out=1 -> data_out held, all chN_ready=0;
//    ready_in=1 -> stream resumes without loss or duplication.
//  - select=11, ch2 valid 0x1234 -> sel_out=01, data_out=0x1234.
//  - rst asserted in LOCKED after beat 1 of 3 -> valid_out=0 next cycle, FSM IDLE,
//    next grant goes to ch1 if valid.

Source files
------------

// File: rtl/mux_3x1_merge_pkg.sv
// rtl/mux_3x1_merge_pkg.sv - shared channel encodings, FSM states and helpers for the 3x1 merge
//
// Purpose: channel tag encodings (shared with the 1x3 channel demux), the
//          merge FSM state type, and tag <-> one-hot conversion helpers.
// Ports:   none (package).

package mux_3x1_merge_pkg;

  localparam logic [1:0] CH1 = 2'b00;
  localparam logic [1:0] CH2 = 2'b01;
  localparam logic [1:0] CH3 = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Tag 2'b11 maps onto ch2 so a forced select of 11 is indistinguishable from 01.
  function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
    logic [2:0] oh;
    case (ch)
      CH1:     oh = 3'b001;
      CH3:     oh = 3'b100;
      default: oh = 3'b010;
    endcase
    return oh;
  endfunction

  // An all-zero vector returns CH1; callers only use the tag when a grant exists.
  function automatic logic [1:0] onehot_ch(input logic [2:0] oh);
    logic [1:0] ch;
    if (oh[2])      ch = CH3;
    else if (oh[1]) ch = CH2;
    else            ch = CH1;
    return ch;
  endfunction

endpackage

// File: rtl/mux_3x1_merge_rr_arbiter_3.sv
// rtl/mux_3x1_merge_rr_arbiter_3.sv - 3-request round-robin arbiter, one-hot grant
//
// Purpose: grants the first requesting channel after rr_last in the circular
//          order ch1 -> ch2 -> ch3 -> ch1. Purely combinational.
// Ports:
//   req      in   3  request vector, bit 0 = ch1
//   rr_last  in   2  tag of the most recently granted channel
//   grant    out  3  one-hot grant, all zero when no request

module rr_arbiter_3
  import mux_3x1_merge_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr_last,
  output logic [2:0] grant
);

  always_comb begin
    grant = 3'b000;
    case (rr_last)
      CH1: begin
        if (req[1])      grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      CH2: begin
        if (req[2])      grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/mux_3x1_merge.sv
// rtl/mux_3x1_merge.sv - registered 3-to-1 result merge with forced/round-robin select and result lock
//
// Purpose: recombines three result channels into one registered output stream.
//          A source is chosen by forced select or round-robin; once a multi-beat
//          result starts, the grant is locked to that channel until its last beat.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   arb_en                       1: round-robin, 0: forced select
//   select[1:0]                  forced source (00 ch1, 01 ch2, 10 ch3, 11 ch2)
//   chN_data/valid/last (N=1..3) channel beat inputs
//   chN_ready                    channel beat accepted when valid & ready
//   data_out/valid_out/last_out  registered merged beat
//   sel_out[1:0]                 source tag of data_out
//   ready_in                     downstream accept

module mux_3x1_merge
  import mux_3x1_merge_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arb_en,
  input  logic [1:0]   select,
  input  logic [W-1:0] ch1_data,
  input  logic         ch1_valid,
  input  logic         ch1_last,
  output logic         ch1_ready,
  input  logic [W-1:0] ch2_data,
  input  logic         ch2_valid,
  input  logic         ch2_last,
  output logic         ch2_ready,
  input  logic [W-1:0] ch3_data,
  input  logic         ch3_valid,
  input  logic         ch3_last,
  output logic         ch3_ready,
  output logic [W-1:0] data_out,
  output logic         valid_out,
  output logic         last_out,
  output logic [1:0]   sel_out,
  input  logic         ready_in
);

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   lock_ch;
  logic [1:0]   rr_last;

  logic [2:0]   valid_vec;
  logic [2:0]   last_vec;
  logic [2:0]   rr_grant;
  logic [2:0]   grant;
  logic [1:0]   grant_ch;
  logic [2:0]   ready_vec;
  logic         ld;
  logic         accept;
  logic         beat_last;
  logic [W-1:0] beat_data;

  assign valid_vec = {ch3_valid, ch2_valid, ch1_valid};
  assign last_vec  = {ch3_last,  ch2_last,  ch1_last};

  rr_arbiter_3 u_rr_arbiter (
    .req     (valid_vec),
    .rr_last (rr_last),
    .grant   (rr_grant)
  );

  always_comb begin
    ld        = ~valid_out | ready_in;
    grant     = 3'b000;
    state_nxt = state;

    // Only the round-robin path looks at valid; a forced or locked grant is
    // asserted even when the channel has nothing to offer.
    if (state == LOCKED) grant = ch_onehot(lock_ch);
    else if (arb_en)     grant = rr_grant;
    else                 grant = ch_onehot(select);

    grant_ch  = onehot_ch(grant);
    ready_vec = (ld && !rst) ? grant : 3'b000;
    accept    = |(ready_vec & valid_vec);
    beat_last = |(grant & last_vec);

    case (grant_ch)
      CH2:     beat_data = ch2_data;
      CH3:     beat_data = ch3_data;
      default: beat_data = ch1_data;
    endcase

    case (state)
      IDLE:    if (accept && !beat_last) state_nxt = LOCKED;
      LOCKED:  if (accept && beat_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ch1_ready = ready_vec[0];
  assign ch2_ready = ready_vec[1];
  assign ch3_ready = ready_vec[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_ch   <= CH1;
      rr_last   <= CH3;
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
      sel_out   <= CH1;
    end else begin
      state <= state_nxt;

      // Round-robin history only advances on the first beat of a result.
      if (accept && state == IDLE) begin
        rr_last <= grant_ch;
        if (!beat_last) lock_ch <= grant_ch;
      end

      if (ld) begin
        valid_out <= accept;
        if (accept) begin
          data_out <= beat_data;
          last_out <= beat_last;
          sel_out  <= grant_ch;
        end
      end
    end
  end

endmodule
